// File: rtl/fb_pkg.sv
// Shared definitions for the partitioned framebuffer write side.
// Holds the memory geometry (partition count, pixels per word), the
// address-width derivation, the pixel-index address map and the fill
// writer FSM state encoding.
package fb_pkg;

  localparam int PARTITION       = 16;
  localparam int PIXELS_PER_DATA = 4;
  localparam int PART_BITS       = $clog2(PARTITION);
  localparam int LANE_BITS       = $clog2(PIXELS_PER_DATA);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SPAN  = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_t;

  // Byte-address width of one partition for a given resolution.
  function automatic int fb_addr_bits(input int res_x, input int res_y);
    return $clog2(res_x * res_y / PARTITION);
  endfunction

  // Pixel index -> partition holding its word.
  function automatic int unsigned fb_partition(input int unsigned p);
    return (p / PIXELS_PER_DATA) % PARTITION;
  endfunction

  // Pixel index -> word-aligned byte address inside its partition.
  function automatic int unsigned fb_address(input int unsigned p);
    return ((p / PIXELS_PER_DATA) / PARTITION) * PIXELS_PER_DATA;
  endfunction

  // Pixel index -> byte lane inside its word.
  function automatic int unsigned fb_lane(input int unsigned p);
    return p % PIXELS_PER_DATA;
  endfunction

endpackage

// File: rtl/fb_word_mapper.sv
// Combinational word mapper shared by framebuffer writers.
// Ports:
//   pix      in  linear pixel index of the first pixel written this word
//   end_lane in  last lane (inclusive) to enable in this word
//   part     out partition owning the word
//   addr     out word-aligned byte address inside that partition
//   mask     out lane enables, lanes lane(pix)..end_lane set
module fb_word_mapper
  import fb_pkg::*;
#(
  parameter int PIX_BITS  = 17,
  parameter int ADDR_BITS = 13
) (
  input  logic [PIX_BITS-1:0]        pix,
  input  logic [LANE_BITS-1:0]       end_lane,
  output logic [PART_BITS-1:0]       part,
  output logic [ADDR_BITS-1:0]       addr,
  output logic [PIXELS_PER_DATA-1:0] mask
);

  logic [LANE_BITS-1:0] lane;

  always_comb begin
    part = PART_BITS'(fb_partition(32'(pix)));
    addr = ADDR_BITS'(fb_address(32'(pix)));
    lane = LANE_BITS'(fb_lane(32'(pix)));
    mask = '0;
    for (int i = 0; i < PIXELS_PER_DATA; i++) begin
      mask[i] = (LANE_BITS'(i) >= lane) && (LANE_BITS'(i) <= end_lane);
    end
  end

endmodule

// File: rtl/fb_fill_writer.sv
// Rectangle-fill producer for the partitioned framebuffer.
// Accepts one solid-colour fill command (inclusive corners) over
// valid/ready, walks it row by row and emits one aligned 4-pixel word
// per cycle on the per-partition write port.
// Ports:
//   wr_clk, wr_reset_n           clock, synchronous active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_x0/x1, cmd_y0/y1         inclusive rectangle bounds
//   cmd_color                    fill colour
//   wr_pxl_addr/wr_pxl_data      per-partition address and lane data
//   wr_en                        per-partition lane enables
//   busy, done, cmd_error        status; done/cmd_error are 1-cycle pulses
module fb_fill_writer
  import fb_pkg::*;
#(
  parameter int RESOLUTION_X = 400,
  parameter int RESOLUTION_Y = 300,
  parameter int PIXEL_BITS   = 8,
  localparam int X_BITS      = $clog2(RESOLUTION_X),
  localparam int Y_BITS      = $clog2(RESOLUTION_Y),
  localparam int ADDR_BITS   = fb_addr_bits(RESOLUTION_X, RESOLUTION_Y)
) (
  input  logic                     wr_clk,
  input  logic                     wr_reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [X_BITS-1:0]        cmd_x0,
  input  logic [X_BITS-1:0]        cmd_x1,
  input  logic [Y_BITS-1:0]        cmd_y0,
  input  logic [Y_BITS-1:0]        cmd_y1,
  input  logic [PIXEL_BITS-1:0]    cmd_color,
  output logic [PARTITION-1:0][ADDR_BITS-1:0]                       wr_pxl_addr,
  output logic [PARTITION-1:0][PIXELS_PER_DATA-1:0][PIXEL_BITS-1:0] wr_pxl_data,
  output logic [PARTITION-1:0][PIXELS_PER_DATA-1:0]                 wr_en,
  output logic                     busy,
  output logic                     done,
  output logic                     cmd_error
);

  localparam int PIX_BITS = $clog2(RESOLUTION_X * RESOLUTION_Y);
  localparam logic [X_BITS-1:0]   X_MAX    = X_BITS'(RESOLUTION_X - 1);
  localparam logic [Y_BITS-1:0]   Y_MAX    = Y_BITS'(RESOLUTION_Y - 1);
  localparam logic [X_BITS:0]     X_LIM    = (X_BITS+1)'(RESOLUTION_X);
  localparam logic [Y_BITS:0]     Y_LIM    = (Y_BITS+1)'(RESOLUTION_Y);
  localparam logic [PIX_BITS-1:0] ROW_STEP = PIX_BITS'(RESOLUTION_X);

  fill_state_t state, state_nxt;

  // Captured command and walk position (data path, not reset)
  logic [X_BITS-1:0]   x0_r, x1_r, x_r;
  logic [Y_BITS-1:0]   y0_r, y1_r, y_r;
  logic [PIX_BITS-1:0] base_r;
  logic                err_r;

  logic                 accept, bad, vld_p0, row_last, last_word;
  logic                 done_nxt, err_nxt, busy_nxt, ready_nxt;
  logic [X_BITS-1:0]    cur_x, x_adv;
  logic [Y_BITS-1:0]    cur_y;
  logic [PIX_BITS-1:0]  cur_base, pix;
  logic [LANE_BITS-1:0] lane, end_lane;
  logic [X_BITS:0]      reach;
  logic [2:0]           cnt;
  logic [PART_BITS-1:0] part;
  logic [ADDR_BITS-1:0] addr;
  logic [PIXELS_PER_DATA-1:0] mask;

  // Stage p0: current word. SETUP walks the first word straight from the
  // captured corner (the only multiply), SPAN from the running row base.
  always_comb begin
    accept   = cmd_valid && cmd_ready;
    bad      = (x0_r > x1_r) || (y0_r > y1_r) ||
               ({1'b0, x0_r} >= X_LIM) || ({1'b0, y0_r} >= Y_LIM);
    cur_x    = (state == ST_SETUP) ? x0_r : x_r;
    cur_y    = (state == ST_SETUP) ? y0_r : y_r;
    cur_base = (state == ST_SETUP) ? PIX_BITS'(y0_r) * ROW_STEP : base_r;
    pix      = cur_base + PIX_BITS'(cur_x);
    lane     = LANE_BITS'(fb_lane(32'(pix)));
    // lane + pixels left in the row; <=3 means the row ends in this word
    reach    = {1'b0, x1_r} - {1'b0, cur_x} + (X_BITS+1)'(lane);
    row_last = (reach <= (X_BITS+1)'(PIXELS_PER_DATA - 1));
    end_lane = row_last ? reach[LANE_BITS-1:0] : LANE_BITS'(PIXELS_PER_DATA - 1);
    cnt      = {1'b0, end_lane} - {1'b0, lane} + 3'd1;
    x_adv    = cur_x + X_BITS'(cnt);
    last_word = row_last && (cur_y == y1_r);
  end

  fb_word_mapper #(
    .PIX_BITS  (PIX_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_map (
    .pix      (pix),
    .end_lane (end_lane),
    .part     (part),
    .addr     (addr),
    .mask     (mask)
  );

  always_comb begin
    state_nxt = state;
    vld_p0    = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = err_r;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SETUP;
      ST_SETUP: begin
        err_nxt = bad;
        if (bad) begin
          // Rejected rectangle reports immediately; DONE is only a dwell.
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
        end else begin
          vld_p0    = 1'b1;
          state_nxt = last_word ? ST_DONE : ST_SPAN;
        end
      end
      ST_SPAN: begin
        vld_p0 = 1'b1;
        if (last_word) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        done_nxt  = !err_r;
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy_nxt  = (state_nxt == ST_SETUP) || (state_nxt == ST_SPAN) ||
                ((state_nxt == ST_DONE) && !err_nxt);
    ready_nxt = (state_nxt == ST_IDLE) && !done_nxt;
  end

  always_ff @(posedge wr_clk) begin
    if (accept) begin
      x0_r <= cmd_x0;
      x1_r <= (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
      y0_r <= cmd_y0;
      y1_r <= (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
    end
    if (vld_p0) begin
      if (row_last) begin
        x_r    <= x0_r;
        y_r    <= cur_y + Y_BITS'(1);
        base_r <= cur_base + ROW_STEP;
      end else begin
        x_r    <= x_adv;
        y_r    <= cur_y;
        base_r <= cur_base;
      end
    end
  end

  // Stage p1: registered control and write port
  always_ff @(posedge wr_clk) begin
    if (!wr_reset_n) begin
      state       <= ST_IDLE;
      err_r       <= 1'b0;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cmd_error   <= 1'b0;
      wr_en       <= '0;
      wr_pxl_addr <= '0;
      wr_pxl_data <= '0;
    end else begin
      state     <= state_nxt;
      err_r     <= err_nxt;
      cmd_ready <= ready_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      cmd_error <= (state == ST_SETUP) && bad;
      wr_en       <= '0;
      wr_pxl_addr <= '0;
      if (vld_p0) begin
        wr_en[part]       <= mask;
        wr_pxl_addr[part] <= addr;
      end
      if (accept) wr_pxl_data <= {(PARTITION*PIXELS_PER_DATA){cmd_color}};
    end
  end

endmodule

// File: tb/tb_fb_fill_writer.sv
module tb_fb_fill_writer;

  logic        wr_clk = 1'b0;
  logic        wr_reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x0, cmd_x1, cmd_y0, cmd_y1;
  logic [7:0]  cmd_color;
  logic [15:0][12:0]     wr_pxl_addr;
  logic [15:0][3:0][7:0] wr_pxl_data;
  logic [15:0][3:0]      wr_en;
  logic        busy, done, cmd_error;

  int checks = 0;
  int errors = 0;

  fb_fill_writer dut (
    .wr_clk      (wr_clk),
    .wr_reset_n  (wr_reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_x0      (cmd_x0),
    .cmd_x1      (cmd_x1),
    .cmd_y0      (cmd_y0),
    .cmd_y1      (cmd_y1),
    .cmd_color   (cmd_color),
    .wr_pxl_addr (wr_pxl_addr),
    .wr_pxl_data (wr_pxl_data),
    .wr_en       (wr_en),
    .busy        (busy),
    .done        (done),
    .cmd_error   (cmd_error)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one command while cmd_ready is high; returns in cycle T+1.
  task automatic issue(input int x0, input int x1, input int y0, input int y1,
                       input logic [7:0] c);
    cmd_x0 = 9'(x0); cmd_x1 = 9'(x1);
    cmd_y0 = 9'(y0); cmd_y1 = 9'(y1);
    cmd_color = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  logic [63:0] exp_en;
  logic [1023:0] written, wanted;
  int ndone, rdy_cyc, mism;

  initial begin
    wr_reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0; cmd_color = '0;
    repeat (3) tick();

    // Reset state
    check("rst_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", cmd_error, 0);
    check("rst_en", wr_en, 0);
    check("rst_addr", wr_pxl_addr, 0);
    check("rst_data", wr_pxl_data, 0);
    wr_reset_n = 1'b1;
    tick();
    check("ready_after_rst", cmd_ready, 1);

    // Single pixel (5,0): partition 1, address 0, lane 1
    issue(5, 5, 0, 0, 8'hAB);
    check("px_t1_ready", cmd_ready, 0);
    check("px_t1_busy", busy, 1);
    check("px_t1_en", wr_en, 0);
    tick();
    check("px_en", wr_en, 64'h20);
    check("px_addr", wr_pxl_addr, 0);
    check("px_data", wr_pxl_data, {64{8'hAB}});
    check("px_t2_done", done, 0);
    tick();
    check("px_done", done, 1);
    check("px_busy_fall", busy, 0);
    check("px_err", cmd_error, 0);
    check("px_en_off", wr_en, 0);
    tick();
    check("px_done_pulse", done, 0);
    check("px_ready_back", cmd_ready, 1);

    // Unaligned span (3,2)-(8,2): p=803..808
    issue(3, 8, 2, 2, 8'h5A);
    tick();
    check("span_w0_en", wr_en, 64'h0000_0008_0000_0000);
    check("span_w0_addr", wr_pxl_addr[8], 48);
    tick();
    check("span_w1_en", wr_en, 64'h0000_00F0_0000_0000);
    check("span_w1_addr", wr_pxl_addr[9], 48);
    check("span_data", wr_pxl_data, {64{8'h5A}});
    tick();
    check("span_w2_en", wr_en, 64'h0000_0100_0000_0000);
    check("span_w2_addr", wr_pxl_addr[10], 48);
    tick();
    check("span_done", done, 1);
    check("span_en_off", wr_en, 0);
    tick();

    // Full row (0,0)-(399,0): 100 words, no bubbles
    issue(0, 399, 0, 0, 8'h11);
    for (int k = 0; k < 100; k++) begin
      tick();
      exp_en = 64'hF << (4 * (k % 16));
      check($sformatf("row_en_%0d", k), wr_en, exp_en);
      check($sformatf("row_addr_%0d", k), wr_pxl_addr[k % 16], (k / 16) * 4);
      check($sformatf("row_busy_%0d", k), busy, 1);
    end
    tick();
    check("row_done", done, 1);
    check("row_en_off", wr_en, 0);
    tick();
    check("row_ready", cmd_ready, 1);

    // Invalid x0 > x1
    issue(10, 5, 0, 0, 8'h22);
    check("inv_t1_en", wr_en, 0);
    tick();
    check("inv_done", done, 1);
    check("inv_err", cmd_error, 1);
    check("inv_en", wr_en, 0);
    check("inv_busy", busy, 0);
    tick();
    check("inv_done_pulse", done, 0);
    check("inv_err_pulse", cmd_error, 0);
    check("inv_ready", cmd_ready, 1);

    // Out-of-range x0 = 450
    issue(450, 460, 0, 0, 8'h33);
    check("oor_t1_en", wr_en, 0);
    tick();
    check("oor_done", done, 1);
    check("oor_err", cmd_error, 1);
    check("oor_en", wr_en, 0);
    tick();
    check("oor_ready", cmd_ready, 1);

    // Back-to-back 2x2 fills with cmd_valid held
    written = '0;
    wanted = '0;
    wanted[0] = 1'b1; wanted[1] = 1'b1; wanted[400] = 1'b1; wanted[401] = 1'b1;
    wanted[402] = 1'b1; wanted[403] = 1'b1; wanted[802] = 1'b1; wanted[803] = 1'b1;
    ndone = 0;
    rdy_cyc = -1;
    issue(0, 1, 0, 1, 8'h44);
    cmd_valid = 1'b1;
    cmd_x0 = 9'd2; cmd_x1 = 9'd3; cmd_y0 = 9'd1; cmd_y1 = 9'd2;
    for (int i = 0; i < 30; i++) begin
      tick();
      for (int pt = 0; pt < 16; pt++)
        for (int ln = 0; ln < 4; ln++)
          if (wr_en[pt][ln] === 1'b1)
            written[((wr_pxl_addr[pt] / 4) * 16 + pt) * 4 + ln] = 1'b1;
      if (done === 1'b1) ndone++;
      if (rdy_cyc >= 0 && i == rdy_cyc + 1) begin
        check("b2b_accepted_busy", busy, 1);
        check("b2b_accepted_ready", cmd_ready, 0);
        cmd_valid = 1'b0;
      end
      if (rdy_cyc < 0 && cmd_ready === 1'b1) rdy_cyc = i;
    end
    cmd_valid = 1'b0;
    mism = 0;
    for (int p = 0; p < 1024; p++) if (written[p] !== wanted[p]) mism++;
    check("b2b_union_mismatches", mism, 0);
    check("b2b_done_count", ndone, 2);
    check("b2b_ready_seen", (rdy_cyc >= 0), 1);
    check("b2b_idle_ready", cmd_ready, 1);

    // Reset in the middle of a full-screen fill
    issue(0, 399, 0, 299, 8'h77);
    repeat (20) tick();
    check("mid_writing", |wr_en, 1);
    wr_reset_n = 1'b0;
    tick();
    check("mid_rst_en", wr_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", cmd_ready, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_addr", wr_pxl_addr, 0);
    check("mid_rst_data", wr_pxl_data, 0);
    tick();
    check("mid_rst_en_hold", wr_en, 0);
    wr_reset_n = 1'b1;
    tick();
    check("post_rst_ready", cmd_ready, 1);
    issue(5, 5, 0, 0, 8'h3C);
    check("post_rst_busy", busy, 1);
    tick();
    check("post_rst_en", wr_en, 64'h20);
    check("post_rst_data", wr_pxl_data, {64{8'h3C}});
    tick();
    check("post_rst_done", done, 1);
    check("post_rst_en_off", wr_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
